// File: rtl/pair_stim_gen.sv
// pair_stim_gen
// Stimulus generator and checker for a 2-bit inequality comparator.
// A run is requested with START. The block then presents all 16 vectors
// {x1,x0,y1,y0} = 0..15, holding each one for STEP_CYCLES cycles. On the
// last cycle of each hold it compares the DUT's mismatch flag with the
// expected one and counts any disagreement.
//
// Ports
//   CLOCK_50 : in  1  sole clock, rising edge
//   RESET    : in  1  synchronous active-high reset
//   START    : in  1  run request, honoured only in IDLE
//   DUT_NEQ  : in  1  mismatch flag returned by the comparator under test
//   XY       : out 4  presented vector {x1,x0,y1,y0}
//   VALID    : out 1  XY carries a live vector
//   EXP_NEQ  : out 1  expected mismatch for XY (0 while VALID=0)
//   BUSY     : out 1  run in progress
//   DONE     : out 1  one-cycle pulse at run completion
//   ERR_CNT  : out 5  disagreements counted in the last run
//   PASS     : out 1  last completed run had no disagreements
module pair_stim_gen #(
    parameter int STEP_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic       DUT_NEQ,
    output logic [3:0] XY,
    output logic       VALID,
    output logic       EXP_NEQ,
    output logic       BUSY,
    output logic       DONE,
    output logic [4:0] ERR_CNT,
    output logic       PASS
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    localparam logic [7:0] LAST_DWELL = 8'(STEP_CYCLES - 1);

    // Expected comparator answer: any bit pair differs.
    function automatic logic neq_of(input logic [3:0] v);
        return (v[3] ^ v[1]) | (v[2] ^ v[0]);
    endfunction

    state_t     state_r, state_s;
    logic [7:0] dwell_r, dwell_s;
    logic [3:0] k_r, k_s;
    logic [3:0] xy_r, xy_s;
    logic       valid_r, valid_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic [4:0] err_r, err_s;
    logic       pass_r, pass_s;

    // Next-state and next-output computation for the run sequencer.
    always_comb begin
        state_s = state_r;
        dwell_s = dwell_r;
        k_s     = k_r;
        xy_s    = xy_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        err_s   = err_r;
        pass_s  = pass_r;
        case (state_r)
            IDLE: begin
                xy_s    = 4'd0;
                valid_s = 1'b0;
                busy_s  = 1'b0;
                dwell_s = 8'd0;
                k_s     = 4'd0;
                if (START) begin
                    state_s = RUN;
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                    err_s   = 5'd0;
                    pass_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (dwell_r == LAST_DWELL) begin
                    dwell_s = 8'd0;
                    // The DUT answer is only trusted at the end of the hold.
                    if (DUT_NEQ != neq_of(xy_r)) begin
                        err_s = err_r + 5'd1;
                    end else begin
                        err_s = err_r;
                    end
                    if (k_r == 4'd15) begin
                        state_s = FIN;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        valid_s = 1'b0;
                        xy_s    = 4'd0;
                        k_s     = 4'd0;
                        // Verdict includes the final vector's sample.
                        pass_s  = (err_s == 5'd0);
                    end else begin
                        k_s  = k_r + 4'd1;
                        xy_s = k_r + 4'd1;
                    end
                end else begin
                    dwell_s = dwell_r + 8'd1;
                end
            end
            FIN: begin
                // START is deliberately ignored here.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                dwell_s = 8'd0;
                k_s     = 4'd0;
                xy_s    = 4'd0;
                valid_s = 1'b0;
                busy_s  = 1'b0;
                err_s   = 5'd0;
                pass_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_r <= IDLE;
            dwell_r <= 8'd0;
            k_r     <= 4'd0;
            xy_r    <= 4'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 5'd0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            dwell_r <= dwell_s;
            k_r     <= k_s;
            xy_r    <= xy_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
            pass_r  <= pass_s;
        end
    end

    assign XY      = xy_r;
    assign VALID   = valid_r;
    assign EXP_NEQ = valid_r & neq_of(xy_r);
    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign ERR_CNT = err_r;
    assign PASS    = pass_r;

endmodule

// File: tb/tb_pair_stim_gen.sv
// Self-checking bench for pair_stim_gen: two instances (hold of 4 and 1
// cycles) driven with randomized comparator answers and compared each
// cycle against a cycle-offset reference model.
module tb_pair_stim_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, start1, neq4, neq1;
    logic [3:0] xy4, xy1;
    logic       v4, v1, e4, e1, b4, b1, d4, d1, p4, p1;
    logic [4:0] ec4, ec1;

    pair_stim_gen #(.STEP_CYCLES(4)) u4 (
        .CLOCK_50(clk), .RESET(rst), .START(start4), .DUT_NEQ(neq4),
        .XY(xy4), .VALID(v4), .EXP_NEQ(e4), .BUSY(b4), .DONE(d4),
        .ERR_CNT(ec4), .PASS(p4)
    );

    pair_stim_gen #(.STEP_CYCLES(1)) u1 (
        .CLOCK_50(clk), .RESET(rst), .START(start1), .DUT_NEQ(neq1),
        .XY(xy1), .VALID(v1), .EXP_NEQ(e1), .BUSY(b1), .DONE(d1),
        .ERR_CNT(ec1), .PASS(p1)
    );

    int total = 0;
    int bad   = 0;
    int sel   = 4;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected mismatch: x1 vs y1 or x0 vs y0 differ.
    function automatic int ref_neq(input int v);
        int x1, x0, y1, y0;
        x1 = (v >> 3) & 1; x0 = (v >> 2) & 1;
        y1 = (v >> 1) & 1; y0 = v & 1;
        return ((x1 != y1) || (x0 != y0)) ? 1 : 0;
    endfunction

    task automatic check_outs(input string tag, input int xy, input int valid,
                              input int busy, input int done, input int err,
                              input int pass);
        int exp_e;
        exp_e = valid ? ref_neq(xy) : 0;
        if (sel == 4) begin
            check_val({tag, "4.xy"}, int'(xy4), xy);
            check_val({tag, "4.valid"}, int'(v4), valid);
            check_val({tag, "4.exp_neq"}, int'(e4), exp_e);
            check_val({tag, "4.busy"}, int'(b4), busy);
            check_val({tag, "4.done"}, int'(d4), done);
            check_val({tag, "4.err_cnt"}, int'(ec4), err);
            check_val({tag, "4.pass"}, int'(p4), pass);
        end else begin
            check_val({tag, "1.xy"}, int'(xy1), xy);
            check_val({tag, "1.valid"}, int'(v1), valid);
            check_val({tag, "1.exp_neq"}, int'(e1), exp_e);
            check_val({tag, "1.busy"}, int'(b1), busy);
            check_val({tag, "1.done"}, int'(d1), done);
            check_val({tag, "1.err_cnt"}, int'(ec1), err);
            check_val({tag, "1.pass"}, int'(p1), pass);
        end
    endtask

    task automatic set_in(input bit st, input bit n);
        if (sel == 4) begin
            start4 = st; neq4 = n; start1 = 1'b0; neq1 = 1'b0;
        end else begin
            start1 = st; neq1 = n; start4 = 1'b0; neq4 = 1'b0;
        end
    endtask

    // mode: 0 ideal comparator, 1 tied 0, 2 tied 1, 3 random answers.
    // abort_k >= 0 pulses RESET on the first cycle of vector abort_k.
    task automatic run_one(input int mode, input int abort_k);
        int nv[16];
        int sc, tot_err, k, errk, n, last;
        bit st;
        sc = sel;
        tot_err = 0;
        for (int j = 0; j < 16; j++) begin
            case (mode)
                0: nv[j] = ref_neq(j);
                1: nv[j] = 0;
                2: nv[j] = 1;
                default: nv[j] = int'($urandom_range(1, 0));
            endcase
            if (nv[j] != ref_neq(j)) tot_err++;
        end
        @(negedge clk);
        set_in(1'b1, 1'b0);
        @(posedge clk);
        last = 16 * sc;
        for (int c = 1; c <= last + 3; c++) begin
            @(negedge clk);
            k = 0;
            if (c <= last) begin
                k = (c - 1) / sc;
                errk = 0;
                for (int j = 0; j < k; j++) if (nv[j] != ref_neq(j)) errk++;
                check_outs("run", k, 1, 1, 0, errk, 0);
            end else if (c == last + 1) begin
                check_outs("fin", 0, 0, 0, 1, tot_err, (tot_err == 0) ? 1 : 0);
            end else begin
                check_outs("idle", 0, 0, 0, 0, tot_err, (tot_err == 0) ? 1 : 0);
            end
            if (abort_k >= 0 && c == abort_k * sc + 1) begin
                rst = 1'b1;
                set_in(1'b0, 1'b0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check_outs("rst", 0, 0, 0, 0, 0, 0);
                return;
            end
            // Re-pulse START mid-run (k=7) and in the FIN cycle.
            st = (c == 7 * sc + 1) || (c == last + 1);
            n = 0;
            if (c <= last) begin
                if (c == (k + 1) * sc) n = nv[k];
                else if (mode == 1) n = 0;
                else if (mode == 2) n = 1;
                else n = int'($urandom_range(1, 0));
            end
            set_in(st, n[0]);
            @(posedge clk);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; start1 = 1'b0; neq4 = 1'b0; neq1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 4; check_outs("reset", 0, 0, 0, 0, 0, 0);
        sel = 1; check_outs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sel = 4; check_outs("hold", 0, 0, 0, 0, 0, 0);

        sel = 4;
        run_one(0, -1);
        run_one(1, -1);
        run_one(2, -1);
        run_one(3, -1);
        run_one(3, -1);
        run_one(0, 5);
        run_one(0, -1);

        // START and RESET together: reset wins, block stays idle.
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0);
        check_outs("sr", 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_outs("sr_idle", 0, 0, 0, 0, 0, 0);

        sel = 1;
        run_one(0, -1);
        run_one(3, -1);
        run_one(1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
